// File: rtl/lwir_pkg.sv
// Shared types for the LWIR pixel packer: FSM states, beat format, lane geometry.
package lwir_pkg;
    localparam int LANE_W = 16;
    localparam int LANES  = 4;
    localparam int BEAT_W = LANE_W * LANES;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        IN_LINE,
        LINE_END,
        DROP
    } state_t;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              user;
        logic              last;
    } beat_t;
endpackage

// File: rtl/lwir_beat_fifo.sv
// Beat FIFO with a registered head. The head register counts as one of the
// DEPTH slots, so 'full' means DEPTH beats are held in total.
module lwir_beat_fifo
    import lwir_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  ref_clk,
    input  logic  rstb,
    input  logic  wr_en,
    input  beat_t wr_beat,
    output logic  full,
    input  logic  rd_rdy,
    output logic  rd_vld,
    output beat_t rd_beat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    beat_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt;
    logic           empty, pop_mem;

    assign empty   = (cnt == '0);
    // Refill the head whenever it is free or being consumed this cycle.
    assign pop_mem = !empty && (!rd_vld || rd_rdy);
    assign full    = (cnt + CW'(rd_vld)) >= CW'(DEPTH);

    // Pointers, occupancy and the registered head.
    always_ff @(posedge ref_clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_vld  <= 1'b0;
            rd_beat <= '0;
        end else begin
            if (wr_en)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_mem) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(wr_en) - CW'(pop_mem);
            if (pop_mem) begin
                rd_beat <= mem[rd_ptr];
                rd_vld  <= 1'b1;
            end else if (rd_rdy) begin
                rd_vld  <= 1'b0;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge ref_clk) begin
        if (wr_en) mem[wr_ptr] <= wr_beat;
    end
endmodule

// File: rtl/lwir_pix_packer.sv
// LWIR pixel packer: checks frame geometry, packs 4 pixels per 64-bit beat
// and streams them out through a small FIFO. Faults are sticky flags.
module lwir_pix_packer
    import lwir_pkg::*;
#(
    parameter int PIX_W       = 14,
    parameter int LINE_PIX    = 640,
    parameter int FRAME_LINES = 512,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             ref_clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             pix_fv,
    input  logic             pix_lv,
    input  logic             pix_vld,
    input  logic [PIX_W-1:0] pix_data,
    output logic [63:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tuser,
    output logic             m_tlast,
    input  logic             err_clr,
    output logic             err_ovf,
    output logic             err_geom,
    output logic [15:0]      frame_cnt
);
    localparam int PC_W = $clog2(LINE_PIX + 1);
    localparam int LC_W = $clog2(FRAME_LINES + 1);

    state_t                        state, state_nxt;
    logic                          fv_q;
    logic [PC_W-1:0]               pix_cnt;
    logic [LC_W-1:0]               line_cnt;
    logic [LANES-2:0][LANE_W-1:0]  lanes;   // lane 3 comes straight from the pixel bus
    logic                          sof_pend, frame_err;
    logic                          pix_ok, fv_rise;
    logic                          take, push, ovf, line_done, geom_set, frame_ok, frame_start;
    logic                          fifo_full, fifo_wr;
    beat_t                         beat, head;

    assign pix_ok  = pix_fv && pix_lv && pix_vld;
    assign fv_rise = pix_fv && !fv_q;
    assign beat    = '{data: {LANE_W'(pix_data), lanes},
                       user: sof_pend,
                       last: (pix_cnt == PC_W'(LINE_PIX - 1))};
    assign fifo_wr = push && !ovf;

    // Next state and per-cycle events for the frame/line tracker.
    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        push        = 1'b0;
        line_done   = 1'b0;
        geom_set    = 1'b0;
        frame_ok    = 1'b0;
        frame_start = 1'b0;
        ovf         = 1'b0;
        unique case (state)
            IDLE: if (fv_rise) begin
                state_nxt   = en ? WAIT_LINE : DROP;
                frame_start = en;
            end
            WAIT_LINE: begin
                if (!pix_fv) begin
                    if (line_cnt == LC_W'(FRAME_LINES) && !frame_err) frame_ok = 1'b1;
                    else                                              geom_set = 1'b1;
                    state_nxt = IDLE;
                end else if (pix_lv && pix_vld) begin
                    if (line_cnt == LC_W'(FRAME_LINES)) begin
                        geom_set  = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        take      = 1'b1;
                        state_nxt = IN_LINE;
                    end
                end
            end
            IN_LINE: begin
                if (pix_ok) begin
                    take = 1'b1;
                    push = (pix_cnt[1:0] == 2'd3);
                    if (pix_cnt == PC_W'(LINE_PIX - 1)) begin
                        line_done = 1'b1;
                        state_nxt = LINE_END;
                    end
                end else if (!pix_fv || !pix_lv) begin
                    geom_set  = 1'b1;
                    state_nxt = DROP;
                end
            end
            LINE_END: begin
                if (pix_ok) geom_set = 1'b1;
                if (!pix_fv || !pix_lv) state_nxt = WAIT_LINE;
            end
            DROP: if (!pix_fv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A beat that finds no room loses the rest of the frame.
        ovf = push && fifo_full && !(m_tvalid && m_tready);
        if (ovf) state_nxt = DROP;
    end

    // State, counters, lane capture and sticky flags.
    always_ff @(posedge ref_clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            fv_q      <= 1'b1;  // treat fv as already high so a frame in progress is never joined
            pix_cnt   <= '0;
            line_cnt  <= '0;
            lanes     <= '0;
            sof_pend  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_ovf   <= 1'b0;
            err_geom  <= 1'b0;
        end else begin
            state <= state_nxt;
            fv_q  <= pix_fv;
            if (frame_start) begin
                line_cnt  <= '0;
                pix_cnt   <= '0;
                sof_pend  <= 1'b1;
                frame_err <= 1'b0;
            end
            if (take) begin
                if (pix_cnt[1:0] != 2'd3) lanes[pix_cnt[1:0]] <= LANE_W'(pix_data);
                pix_cnt <= line_done ? '0 : pix_cnt + PC_W'(1);
            end
            if (fifo_wr)   sof_pend  <= 1'b0;
            if (line_done) line_cnt  <= line_cnt + LC_W'(1);
            if (geom_set)  frame_err <= 1'b1;
            if (frame_ok)  frame_cnt <= frame_cnt + 16'd1;
            err_ovf  <= ovf      || (err_ovf  && !err_clr);
            err_geom <= geom_set || (err_geom && !err_clr);
        end
    end

    lwir_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .ref_clk (ref_clk),
        .rstb    (rstb),
        .wr_en   (fifo_wr),
        .wr_beat (beat),
        .full    (fifo_full),
        .rd_rdy  (m_tready),
        .rd_vld  (m_tvalid),
        .rd_beat (head)
    );

    assign m_tdata = head.data;
    assign m_tuser = head.user;
    assign m_tlast = head.last;
endmodule

// File: doc/lwir_pix_packer.md
Name: lwir_pix_packer

Overview:
- PL stage directly downstream of the LWIR sensor pins inside the lwircam top.
- Receives the raw 14-bit pixel stream qualified by frame/line valid and checks frame geometry.
- Packs four pixels per 64-bit beat and presents an AXI-Stream master toward the DDR write DMA.
- The sensor cannot be stalled, so a small FIFO absorbs downstream back-pressure; overflow and geometry faults are reported as sticky flags.

Parameters:
- PIX_W, 14, sensor pixel width; zero-extended to 16 bits per lane.
- LINE_PIX, 640, pixels per line; must be a multiple of 4.
- FRAME_LINES, 512, lines per frame.
- FIFO_DEPTH, 8, beat FIFO depth; power of 2, at least 2.

Ports:
- ref_clk  in  1  single clock for the whole block.
- rstb  in  1  reset, asynchronous, active-low.
- en  in  1  frame accept enable; sampled only at frame start.
- pix_fv  in  1  frame valid.
- pix_lv  in  1  line valid.
- pix_vld  in  1  pixel strobe; counts only while pix_fv and pix_lv are high.
- pix_data  in  PIX_W  pixel value.
- m_tdata  out  64  packed beat; pixel0 in [15:0], pixel3 in [63:48].
- m_tvalid  out  1  beat valid.
- m_tready  in  1  downstream ready.
- m_tuser  out  1  first beat of frame.
- m_tlast  out  1  last beat of line.
- err_clr  in  1  one-cycle pulse; clears the sticky errors.
- err_ovf  out  1  sticky FIFO overflow.
- err_geom  out  1  sticky geometry error.
- frame_cnt  out  16  frames completed without error; wraps at 0xFFFF to 0.

Behaviour:
- Reset: all outputs 0, FIFO emptied, counters 0, state IDLE.
- Reset asserted mid-frame discards everything. After release the block waits in IDLE for the next pix_fv rising edge and never joins a frame in progress.
- State IDLE:
  - Watches for a rising edge of pix_fv (previous-cycle register).
  - On an edge with en=1: go to WAIT_LINE, line_cnt=0, sof_pend=1.
  - On an edge with en=0: go to DROP.
- State WAIT_LINE:
  - pix_lv=1 with pix_vld=1 → IN_LINE; this pixel is pixel 0.
  - pix_fv falls → frame end check (below).
- State IN_LINE:
  - Each qualifying pixel goes into lane pix_cnt[1:0]; pix_cnt increments.
  - On the 4th lane the beat is pushed with tuser=sof_pend and tlast=(pix_cnt==LINE_PIX-1); sof_pend then clears.
  - When pix_cnt reaches LINE_PIX: line_cnt++ and go to LINE_END.
  - pix_lv falls before LINE_PIX pixels: the partial beat is discarded, err_geom=1, go to DROP.
- State LINE_END:
  - Pixels with pix_lv still high are ignored and set err_geom=1 (long line).
  - pix_lv low → WAIT_LINE.
- State DROP: ignores all input until pix_fv falls, then → IDLE.
- Frame end, on pix_fv fall in WAIT_LINE:
  - If line_cnt==FRAME_LINES and no error occurred in this frame: frame_cnt++.
  - Otherwise err_geom=1.
  - In both cases → IDLE.
  - A line in progress when pix_fv falls is a short line and follows the IN_LINE rule above.
  - If line_cnt reaches FRAME_LINES and another line starts: err_geom=1, go to DROP.
- FIFO:
  - A push when the FIFO is full drops the beat, sets err_ovf=1 and moves to DROP. Beats already queued still drain, so downstream sees a frame truncated without its final tlast.
  - Simultaneous push and pop on a full FIFO is allowed and is not an overflow.
- Output:
  - Registered FIFO head, AXI-Stream rules: tdata, tuser and tlast hold stable while tvalid=1 and tready=0.
  - Transfer occurs when tvalid and tready are both high.
  - Latency: the beat appears on m_tvalid 2 cycles after the cycle of its 4th pixel, when the FIFO is empty and tready=1.
  - Throughput: 1 beat/cycle.
- Sticky errors:
  - err_clr clears err_ovf and err_geom.
  - If err_clr and a new error arrive in the same cycle, the error wins (flag stays 1).
  - err_clr has no effect on state or frame_cnt.
- en falling mid-frame does not abort the frame; it only blocks the next frame start.

Decomposition:
- Package lwir_pkg holds:
  - the state enum (IDLE, WAIT_LINE, IN_LINE, LINE_END, DROP);
  - the beat struct (64-bit data, user, last);
  - lane width 16 and lanes-per-beat 4.
- One sub-module, lwir_beat_fifo: synchronous FIFO of the beat struct with full/empty flags, using the same ref_clk and rstb.

Test Plan:
- Use LINE_PIX=8, FRAME_LINES=2. Send one frame of pixels 1..16 with tready=1 → 4 beats:
  - beat0 = 0x0004_0003_0002_0001 with tuser=1;
  - tlast=1 on beats 1 and 3;
  - frame_cnt=1, no errors.
- Same frame with tready=0 for 20 cycles and FIFO_DEPTH=2 → err_ovf=1, only 2 beats emitted, frame_cnt=0. Next clean frame emits 4 beats and frame_cnt=1.
- Line 2 with pix_lv dropping after 6 pixels → err_geom=1, exactly 3 beats emitted, frame_cnt=0. err_clr pulse → err_geom=0.
- Frame with 3 lines → err_geom=1, 4 beats emitted, 3rd line ignored. Frame with 1 line → err_geom=1 at pix_fv fall.
- en=0 at pix_fv rise → no beats for that frame. en=1 restored mid-frame → still no beats until the next frame.
- rstb low for 1 cycle mid-line → all outputs 0 immediately. Remainder of that frame ignored. Next frame packed correctly with tuser=1 on its first beat.
